mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_if.sv | 39 +++
 rtl/mem_access.sv | 180 ++++++++++++++++++
 tb/tb_mem_access.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_if.sv
// Execute-to-memory stage bundle: execute-stage inputs, data-memory bus and writeback outputs.
// master is the memory-access stage; slave is the surrounding pipeline/memory environment.
interface mem_access_if;
  logic        valid_in;
  logic [5:0]  alucode;
  logic [31:0] alu_result;
  logic [31:0] rs2;
  logic [4:0]  rd_src;
  logic        is_load;
  logic        is_store;
  logic        reg_we;
  logic        stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misaligned_err;

  modport master (
    input  valid_in, alucode, alu_result, rs2, rd_src, is_load, is_store, reg_we,
    input  dmem_ack, dmem_rdata,
    output stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output wb_valid, wb_we, wb_rd, wb_data, misaligned_err
  );

  modport slave (
    output valid_in, alucode, alu_result, rs2, rd_src, is_load, is_store, reg_we,
    output dmem_ack, dmem_rdata,
    input  stall, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  wb_valid, wb_we, wb_rd, wb_data, misaligned_err
  );
endinterface

// File: rtl/mem_access.sv
// Memory-access pipeline stage: passes ALU results to writeback and runs one blocking
// load/store on the data-memory bus, stalling upstream until the memory acknowledges.
module mem_access (
  input logic          clk,
  input logic          rst_n,
  mem_access_if.master bus
);

  localparam logic [5:0] AluLb  = 6'd10;
  localparam logic [5:0] AluLh  = 6'd11;
  localparam logic [5:0] AluLw  = 6'd12;
  localparam logic [5:0] AluLbu = 6'd13;
  localparam logic [5:0] AluLhu = 6'd14;
  localparam logic [5:0] AluSb  = 6'd15;
  localparam logic [5:0] AluSh  = 6'd16;
  localparam logic [5:0] AluSw  = 6'd17;

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [5:0]  op_q, op_d;
  logic [4:0]  rd_q, rd_d;
  logic        reg_we_q, reg_we_d;
  logic        wb_valid_q, wb_valid_d;
  logic        wb_we_q, wb_we_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        mis_err_q, mis_err_d;

  logic        busy;
  logic        is_word, is_half, is_mem, misaligned;
  logic [3:0]  new_be;
  logic [31:0] new_wdata;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign busy = (state_q == StBusy);

  // Decode of the incoming instruction: access size, alignment and lane placement.
  always_comb begin
    is_word    = (bus.alucode == AluLw) || (bus.alucode == AluSw);
    is_half    = (bus.alucode == AluLh) || (bus.alucode == AluLhu) || (bus.alucode == AluSh);
    is_mem     = bus.is_load | bus.is_store;
    misaligned = is_word ? (bus.alu_result[1:0] != 2'b00) : (is_half & bus.alu_result[0]);
    if (is_word) begin
      new_be    = 4'b1111;
      new_wdata = bus.rs2;
    end else if (is_half) begin
      new_be    = bus.alu_result[1] ? 4'b1100 : 4'b0011;
      new_wdata = {2{bus.rs2[15:0]}};
    end else begin
      new_be    = 4'b0001 << bus.alu_result[1:0];
      new_wdata = {4{bus.rs2[7:0]}};
    end
  end

  // Lane extraction of the returned word using the captured address and opcode.
  always_comb begin
    ld_byte = bus.dmem_rdata[7:0];
    unique case (addr_q[1:0])
      2'd0: ld_byte = bus.dmem_rdata[7:0];
      2'd1: ld_byte = bus.dmem_rdata[15:8];
      2'd2: ld_byte = bus.dmem_rdata[23:16];
      2'd3: ld_byte = bus.dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? bus.dmem_rdata[31:16] : bus.dmem_rdata[15:0];
    case (op_q)
      AluLb:   ld_data = {{24{ld_byte[7]}}, ld_byte};
      AluLbu:  ld_data = {24'd0, ld_byte};
      AluLh:   ld_data = {{16{ld_half[15]}}, ld_half};
      AluLhu:  ld_data = {16'd0, ld_half};
      default: ld_data = bus.dmem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    op_d       = op_q;
    rd_d       = rd_q;
    reg_we_d   = reg_we_q;
    wb_valid_d = 1'b0;
    wb_we_d    = wb_we_q;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    mis_err_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.valid_in) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_we_d    = bus.reg_we;
            wb_rd_d    = bus.rd_src;
            wb_data_d  = bus.alu_result;
          end else if (misaligned) begin
            mis_err_d = 1'b1;
          end else begin
            state_d  = StBusy;
            addr_d   = bus.alu_result;
            wdata_d  = new_wdata;
            be_d     = new_be;
            we_d     = bus.is_store;
            op_d     = bus.alucode;
            rd_d     = bus.rd_src;
            reg_we_d = bus.reg_we;
          end
        end
      end
      StBusy: begin
        if (bus.dmem_ack) begin
          state_d    = StIdle;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          if (we_q) begin
            wb_we_d   = 1'b0;
            wb_data_d = 32'd0;
          end else begin
            wb_we_d   = reg_we_q && (rd_q != 5'd0);
            wb_data_d = ld_data;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      be_q       <= 4'd0;
      we_q       <= 1'b0;
      op_q       <= 6'd0;
      rd_q       <= 5'd0;
      reg_we_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_we_q    <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'd0;
      mis_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      reg_we_q   <= reg_we_d;
      wb_valid_q <= wb_valid_d;
      wb_we_q    <= wb_we_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      mis_err_q  <= mis_err_d;
    end
  end

  // Bus outputs are gated by state so nothing stale is driven while idle.
  assign bus.stall          = busy;
  assign bus.dmem_req       = busy;
  assign bus.dmem_we        = busy & we_q;
  assign bus.dmem_addr      = busy ? {addr_q[31:2], 2'b00} : 32'd0;
  assign bus.dmem_be        = busy ? be_q : 4'd0;
  assign bus.dmem_wdata     = busy ? wdata_q : 32'd0;
  assign bus.wb_valid       = wb_valid_q;
  assign bus.wb_we          = wb_we_q;
  assign bus.wb_rd          = wb_rd_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.misaligned_err = mis_err_q;

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: stimulus pushes expected writeback/error events into a
// scoreboard queue that a negedge monitor pops whenever the DUT pulses wb_valid or misaligned_err.
module tb_mem_access;

  localparam logic [5:0] OpAdd = 6'd0;
  localparam logic [5:0] OpLb  = 6'd10;
  localparam logic [5:0] OpLh  = 6'd11;
  localparam logic [5:0] OpLw  = 6'd12;
  localparam logic [5:0] OpLbu = 6'd13;
  localparam logic [5:0] OpLhu = 6'd14;
  localparam logic [5:0] OpSb  = 6'd15;
  localparam logic [5:0] OpSh  = 6'd16;
  localparam logic [5:0] OpSw  = 6'd17;

  typedef struct {
    logic        mis;
    logic        we;
    logic [4:0]  rd;
    logic        chk_rd;
    logic [31:0] data;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  exp_t sb_q[$];
  exp_t mon_e;

  mem_access_if bus ();

  mem_access dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic mis, input logic we, input logic [4:0] rd,
                          input logic chk_rd, input logic [31:0] data);
    exp_t e;
    e.mis    = mis;
    e.we     = we;
    e.rd     = rd;
    e.chk_rd = chk_rd;
    e.data   = data;
    sb_q.push_back(e);
  endtask

  // Monitor: every wb_valid / misaligned_err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (bus.wb_valid || bus.misaligned_err)) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: wb_valid=%0b misaligned_err=%0b, expected none (t=%0t)",
                 bus.wb_valid, bus.misaligned_err, $time);
      end else begin
        mon_e = sb_q.pop_front();
        check("wb_valid", 32'(bus.wb_valid), 32'(!mon_e.mis));
        check("misaligned_err", 32'(bus.misaligned_err), 32'(mon_e.mis));
        if (!mon_e.mis) begin
          check("wb_we", 32'(bus.wb_we), 32'(mon_e.we));
          check("wb_data", bus.wb_data, mon_e.data);
          if (mon_e.chk_rd) check("wb_rd", 32'(bus.wb_rd), 32'(mon_e.rd));
        end
      end
    end
  end

  // All tasks start and end one time unit after a rising edge.
  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd, input logic rwe);
    bus.valid_in   = 1'b1;
    bus.alucode    = OpAdd;
    bus.alu_result = res;
    bus.rd_src     = rd;
    bus.reg_we     = rwe;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    push_exp(1'b0, rwe, rd, 1'b1, res);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    check("alu_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("alu_stall", 32'(bus.stall), 32'd0);
  endtask

  task automatic misaligned_op(input logic [5:0] op, input logic st, input logic [31:0] addr);
    bus.valid_in   = 1'b1;
    bus.alucode    = op;
    bus.alu_result = addr;
    bus.rs2        = 32'hFFFF_FFFF;
    bus.rd_src     = 5'd1;
    bus.reg_we     = 1'b1;
    bus.is_load    = !st;
    bus.is_store   = st;
    push_exp(1'b1, 1'b0, 5'd0, 1'b0, 32'd0);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    check("mis_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("mis_stall", 32'(bus.stall), 32'd0);
  endtask

  task automatic mem_op(input logic [5:0] op, input logic st, input logic [31:0] addr,
                        input logic [31:0] rs2, input logic [4:0] rd, input logic rwe,
                        input int nb, input logic [31:0] rdata, input logic [31:0] eaddr,
                        input logic [3:0] ebe, input logic [31:0] ewdata,
                        input logic ewe, input logic [31:0] edata);
    bus.valid_in   = 1'b1;
    bus.alucode    = op;
    bus.alu_result = addr;
    bus.rs2        = rs2;
    bus.rd_src     = rd;
    bus.reg_we     = rwe;
    bus.is_load    = !st;
    bus.is_store   = st;
    check("pre_dmem_req", 32'(bus.dmem_req), 32'd0);
    @(posedge clk); #1;
    for (int i = 1; i <= nb; i++) begin
      check("busy_stall", 32'(bus.stall), 32'd1);
      check("busy_dmem_req", 32'(bus.dmem_req), 32'd1);
      check("busy_dmem_addr", bus.dmem_addr, eaddr);
      check("busy_dmem_we", 32'(bus.dmem_we), 32'(st));
      if (st) begin
        check("busy_dmem_be", 32'(bus.dmem_be), 32'(ebe));
        check("busy_dmem_wdata", bus.dmem_wdata, ewdata);
      end
      if (i == nb) begin
        push_exp(1'b0, ewe, rd, !st, edata);
        bus.dmem_ack   = 1'b1;
        bus.dmem_rdata = rdata;
      end
      @(posedge clk); #1;
    end
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'h5A5A_5A5A;
    bus.valid_in   = 1'b0;
    check("done_stall", 32'(bus.stall), 32'd0);
    check("done_dmem_req", 32'(bus.dmem_req), 32'd0);
  endtask

  initial begin
    n_cmp          = 0;
    n_err          = 0;
    rst_n          = 1'b0;
    bus.valid_in   = 1'b0;
    bus.alucode    = 6'd0;
    bus.alu_result = 32'd0;
    bus.rs2        = 32'd0;
    bus.rd_src     = 5'd0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b0;
    bus.reg_we     = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_stall", 32'(bus.stall), 32'd0);
    check("rst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
    check("rst_wb_data", bus.wb_data, 32'd0);
    check("rst_misaligned_err", 32'(bus.misaligned_err), 32'd0);
    rst_n = 1'b1;

    alu_op(32'h0000_1234, 5'd5, 1'b1);
    mem_op(OpLb, 1'b0, 32'h103, 32'd0, 5'd7, 1'b1, 3, 32'h80FF_FFFF,
           32'h100, 4'd0, 32'd0, 1'b1, 32'hFFFF_FF80);
    mem_op(OpLhu, 1'b0, 32'h202, 32'd0, 5'd8, 1'b1, 1, 32'hBEEF_1234,
           32'h200, 4'd0, 32'd0, 1'b1, 32'h0000_BEEF);
    mem_op(OpLh, 1'b0, 32'h202, 32'd0, 5'd9, 1'b1, 2, 32'hBEEF_1234,
           32'h200, 4'd0, 32'd0, 1'b1, 32'hFFFF_BEEF);
    mem_op(OpSb, 1'b1, 32'h301, 32'h0000_00AB, 5'd4, 1'b1, 1, 32'd0,
           32'h300, 4'b0010, 32'hABAB_ABAB, 1'b0, 32'd0);
    misaligned_op(OpLw, 1'b0, 32'h402);
    mem_op(OpSh, 1'b1, 32'h402, 32'h1234_CAFE, 5'd4, 1'b1, 2, 32'd0,
           32'h400, 4'b1100, 32'hCAFE_CAFE, 1'b0, 32'd0);
    mem_op(OpSw, 1'b1, 32'h40C, 32'hDEAD_BEEF, 5'd4, 1'b1, 2, 32'd0,
           32'h40C, 4'b1111, 32'hDEAD_BEEF, 1'b0, 32'd0);
    mem_op(OpLw, 1'b0, 32'h410, 32'd0, 5'd10, 1'b1, 1, 32'h1234_5678,
           32'h410, 4'd0, 32'd0, 1'b1, 32'h1234_5678);
    mem_op(OpLbu, 1'b0, 32'h411, 32'd0, 5'd11, 1'b1, 1, 32'h1234_5678,
           32'h410, 4'd0, 32'd0, 1'b1, 32'h0000_0056);
    mem_op(OpLb, 1'b0, 32'h412, 32'd0, 5'd12, 1'b1, 1, 32'h12F4_5678,
           32'h410, 4'd0, 32'd0, 1'b1, 32'hFFFF_FFF4);
    mem_op(OpLw, 1'b0, 32'h414, 32'd0, 5'd0, 1'b1, 1, 32'hCAFE_F00D,
           32'h414, 4'd0, 32'd0, 1'b0, 32'hCAFE_F00D);
    mem_op(OpLhu, 1'b0, 32'h416, 32'd0, 5'd13, 1'b0, 1, 32'h7777_0000,
           32'h414, 4'd0, 32'd0, 1'b0, 32'h0000_7777);
    misaligned_op(OpLh, 1'b0, 32'h401);
    misaligned_op(OpSh, 1'b1, 32'h403);
    misaligned_op(OpSw, 1'b1, 32'h406);
    mem_op(OpSb, 1'b1, 32'h503, 32'h0000_0012, 5'd4, 1'b1, 1, 32'd0,
           32'h500, 4'b1000, 32'h1212_1212, 1'b0, 32'd0);
    alu_op(32'hA5A5_0001, 5'd3, 1'b0);

    // Idle cycles, including a stray ack, must produce no bus or writeback activity.
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'h1111_2222;
    @(posedge clk); #1;
    bus.dmem_ack = 1'b0;
    check("idle_ack_stall", 32'(bus.stall), 32'd0);
    check("idle_ack_dmem_req", 32'(bus.dmem_req), 32'd0);
    repeat (2) @(posedge clk);
    #1;

    // Reset in the middle of a store abandons it asynchronously.
    bus.valid_in   = 1'b1;
    bus.alucode    = OpSw;
    bus.alu_result = 32'h500;
    bus.rs2        = 32'h1122_3344;
    bus.rd_src     = 5'd2;
    bus.reg_we     = 1'b0;
    bus.is_load    = 1'b0;
    bus.is_store   = 1'b1;
    @(posedge clk); #1;
    check("sw_busy_dmem_req", 32'(bus.dmem_req), 32'd1);
    check("sw_busy_dmem_wdata", bus.dmem_wdata, 32'h1122_3344);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_dmem_req", 32'(bus.dmem_req), 32'd0);
    check("arst_stall", 32'(bus.stall), 32'd0);
    check("arst_dmem_we", 32'(bus.dmem_we), 32'd0);
    check("arst_dmem_be", 32'(bus.dmem_be), 32'd0);
    check("arst_dmem_addr", bus.dmem_addr, 32'd0);
    check("arst_dmem_wdata", bus.dmem_wdata, 32'd0);
    check("arst_wb_we", 32'(bus.wb_we), 32'd0);
    check("arst_wb_rd", 32'(bus.wb_rd), 32'd0);
    check("arst_wb_data", bus.wb_data, 32'd0);
    bus.valid_in = 1'b0;
    bus.is_store = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("post_rst_stall", 32'(bus.stall), 32'd0);
    alu_op(32'h0000_0BAD, 5'd6, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
